// File: rtl/duc_interp_pkg.sv
// Shared types and the rate-split rule for the DUC interpolation controller.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package duc_interp_pkg;

  localparam int NUM_HB         = 3;
  localparam int CIC_MAX_INTERP = 255;
  localparam int RATE_W         = 12;
  localparam int HB_W           = $clog2(NUM_HB + 1);

  typedef logic [RATE_W-1:0] rate_t;
  typedef logic [HB_W-1:0]   hb_t;
  typedef logic [7:0]        cic_t;

  localparam rate_t MAX_RATE = rate_t'(CIC_MAX_INTERP << NUM_HB);

  // Packet-boundary tracking for config application
  typedef enum logic {IDLE_BOUNDARY = 1'b0, IN_PACKET = 1'b1} pkt_state_t;

  typedef struct packed {
    hb_t  hb;
    cic_t cic;
    logic err;
  } split_t;

  // Decoded configuration: total rate kept alongside its split
  typedef struct packed {
    rate_t rate;
    hb_t   hb;
    cic_t  cic;
  } dec_t;

  // Peel factors of two into half-bands (up to NUM_HB), remainder goes to the CIC
  function automatic split_t split_rate(input rate_t rate);
    rate_t  r;
    hb_t    hb;
    logic   stop;
    split_t s;
    r    = rate;
    hb   = '0;
    stop = 1'b0;
    for (int i = 0; i < NUM_HB; i++) begin
      if (!stop && !r[0]) begin
        r  = r >> 1;
        hb = hb + hb_t'(1);
      end else begin
        stop = 1'b1;
      end
    end
    s.hb  = hb;
    s.cic = (r == '0) ? 8'd1 : r[7:0];
    s.err = (rate == '0) || (rate > MAX_RATE) || (r > rate_t'(CIC_MAX_INTERP));
    return s;
  endfunction

endpackage

// File: rtl/interp_rate_decode.sv
// Registered decode of a requested interpolation rate into half-band count and CIC rate.
// Latency: 1 cycle from i_cfg_vld to o_dec_vld / o_err.
// Backpressure: none; every strobe is decoded, illegal rates raise a one-cycle o_err.
module interp_rate_decode
  import duc_interp_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_cfg_vld,
  input  rate_t i_cfg_rate,
  output logic  o_dec_vld,
  output dec_t  o_dec,
  output logic  o_err
);

  split_t w_split;
  logic   r_dec_vld;
  logic   r_err;
  dec_t   r_dec;

  assign w_split = split_rate(i_cfg_rate);

  // Capture the split on each strobe; legal and illegal outcomes are mutually exclusive pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dec_vld <= 1'b0;
      r_err     <= 1'b0;
      r_dec     <= '0;
    end else begin
      r_dec_vld <= i_cfg_vld && !w_split.err;
      r_err     <= i_cfg_vld && w_split.err;
      if (i_cfg_vld) begin
        r_dec <= '{rate: i_cfg_rate, hb: w_split.hb, cic: w_split.cic};
      end
    end
  end

  assign o_dec_vld = r_dec_vld;
  assign o_dec     = r_dec;
  assign o_err     = r_err;

endmodule

// File: rtl/duc_interp_ctrl.sv
// Zero-order-hold sample expander and interpolation rate control for the DUC chain.
// Latency: 1 cycle input to first output; config active 2 cycles after cfg_valid when idle.
// Backpressure: s_axis_tready only while no sample is held or its final repeat is leaving.
module duc_interp_ctrl
  import duc_interp_pkg::*;
#(
  parameter int SAMP_W = 32
) (
  input  logic              ce_clk,
  input  logic              ce_rst_n,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              cfg_valid,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic [HB_W-1:0]   hb_enables,
  output logic [7:0]        cic_rate,
  input  logic [SAMP_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [SAMP_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  logic        w_dec_vld;
  dec_t        w_dec;
  logic        w_last_rep;
  logic        w_s_hs;
  logic        w_m_hs;
  logic        w_out_last_hs;
  logic        w_boundary;

  dec_t        r_act;
  dec_t        r_pend_cfg;
  logic        r_pend;
  pkt_state_t  r_state;
  logic        r_m_vld;
  logic [SAMP_W-1:0] r_dat;
  logic        r_last;
  rate_t       r_rep;

  interp_rate_decode u_decode (
    .i_clk      (ce_clk),
    .i_rst_n    (ce_rst_n),
    .i_cfg_vld  (cfg_valid),
    .i_cfg_rate (cfg_rate),
    .o_dec_vld  (w_dec_vld),
    .o_dec      (w_dec),
    .o_err      (cfg_err)
  );

  assign w_last_rep    = (r_rep == (r_act.rate - rate_t'(1)));
  assign s_axis_tready = !r_m_vld || (m_axis_tready && w_last_rep);
  assign w_s_hs        = s_axis_tvalid && s_axis_tready;
  assign w_m_hs        = r_m_vld && m_axis_tready;
  assign w_out_last_hs = w_m_hs && r_last && w_last_rep;
  // Safe to swap rate: nothing in flight, or the closing beat of a packet leaves this cycle
  assign w_boundary    = (r_state == IDLE_BOUNDARY) || w_out_last_hs;

  // Hold register, repeat counter and packet-boundary state
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_m_vld <= 1'b0;
      r_dat   <= '0;
      r_last  <= 1'b0;
      r_rep   <= '0;
      r_state <= IDLE_BOUNDARY;
    end else if (w_s_hs) begin
      r_dat   <= s_axis_tdata;
      r_last  <= s_axis_tlast;
      r_rep   <= '0;
      r_m_vld <= 1'b1;
      r_state <= IN_PACKET;
    end else if (w_m_hs) begin
      if (w_last_rep) begin
        r_m_vld <= 1'b0;
        r_rep   <= '0;
        if (r_last) begin
          r_state <= IDLE_BOUNDARY;
        end
      end else begin
        r_rep <= r_rep + rate_t'(1);
      end
    end
  end

  // Apply decoded rates at boundaries, otherwise park them as pending (newest wins)
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      r_act      <= '{rate: rate_t'(1), hb: '0, cic: 8'd1};
      r_pend_cfg <= '0;
      r_pend     <= 1'b0;
    end else if (w_dec_vld) begin
      if (w_boundary) begin
        r_act  <= w_dec;
        r_pend <= 1'b0;
      end else begin
        r_pend_cfg <= w_dec;
        r_pend     <= 1'b1;
      end
    end else if (r_pend && w_out_last_hs) begin
      r_act  <= r_pend_cfg;
      r_pend <= 1'b0;
    end
  end

  assign cfg_pending   = r_pend;
  assign hb_enables    = r_act.hb;
  assign cic_rate      = r_act.cic;
  assign m_axis_tdata  = r_dat;
  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tlast  = r_last && w_last_rep;

endmodule

// File: tb/tb_duc_interp_ctrl.sv
// Self-checking bench for duc_interp_ctrl with a queue-based zero-order-hold model.
// Latency: n/a.
// Backpressure: randomized m_axis_tready stalls and s_axis_tvalid gaps.
module tb_duc_interp_ctrl;
  import duc_interp_pkg::*;

  logic              ce_clk;
  logic              ce_rst_n;
  logic [RATE_W-1:0] cfg_rate;
  logic              cfg_valid;
  logic              cfg_pending;
  logic              cfg_err;
  logic [HB_W-1:0]   hb_enables;
  logic [7:0]        cic_rate;
  logic [31:0]       s_tdata;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;

  duc_interp_ctrl #(.SAMP_W(32)) dut (
    .ce_clk        (ce_clk),
    .ce_rst_n      (ce_rst_n),
    .cfg_rate      (cfg_rate),
    .cfg_valid     (cfg_valid),
    .cfg_pending   (cfg_pending),
    .cfg_err       (cfg_err),
    .hb_enables    (hb_enables),
    .cic_rate      (cic_rate),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  initial begin
    ce_clk = 1'b0;
    forever #5 ce_clk = ~ce_clk;
  end

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          model_n = 1;
  beat_t       exp_q[$];
  logic [31:0] pkt [0:511];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Rate split straight from the arithmetic rule: halve while even, at most three times
  function automatic void ref_split(input int n, output int hb, output int cic, output bit err);
    hb  = 0;
    cic = n;
    while (hb < 3 && cic != 0 && (cic % 2) == 0) begin
      cic = cic / 2;
      hb++;
    end
    err = (n == 0) || (cic > 255);
    if (cic == 0) cic = 1;
  endfunction

  task automatic check_active(input string tag);
    int hb, cic;
    bit e;
    ref_split(model_n, hb, cic, e);
    check({tag, "_hb"}, 64'(hb_enables), 64'(hb));
    check({tag, "_cic"}, 64'(cic_rate), 64'(cic));
  endtask

  task automatic set_cfg(input int n);
    int hb, cic;
    bit e;
    ref_split(n, hb, cic, e);
    @(negedge ce_clk);
    cfg_rate  = RATE_W'(n);
    cfg_valid = 1'b1;
    @(negedge ce_clk);
    cfg_valid = 1'b0;
    check("cfg_err_pulse", 64'(cfg_err), 64'(e));
    @(negedge ce_clk);
    check("cfg_err_clear", 64'(cfg_err), 64'(0));
    if (!e) model_n = n;
    check_active("cfg");
    check("cfg_pend_idle", 64'(cfg_pending), 64'(0));
  endtask

  // Drive one packet and score every output beat against the expanded expectation
  task automatic run_packet(input int len, input int stall_pct, input int in_pct, input bit seq,
                            input int cfg_at, input int cfg_val, input int abort_cyc,
                            input bit chk_rdy);
    int          n;
    int          sent;
    int          cfg_cyc;
    bit          cfg_done;
    bit          acc;
    bit          aborted;
    bit          rdy;
    bit          prev_vld;
    bit          prev_rdy;
    logic [31:0] prev_d;
    logic        prev_l;
    beat_t       b;
    n        = model_n;
    sent     = 0;
    cfg_cyc  = 0;
    cfg_done = 1'b0;
    acc      = 1'b0;
    aborted  = 1'b0;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_d   = '0;
    prev_l   = 1'b0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      pkt[i] = seq ? {16'(i + 1), 16'(i + 1)} : $urandom;
      for (int r = 0; r < n; r++) begin
        b.d = pkt[i];
        b.l = (i == len - 1) && (r == n - 1);
        exp_q.push_back(b);
      end
    end
    for (int cyc = 0; cyc < 20000 && !(exp_q.size() == 0 && sent == len); cyc++) begin
      @(negedge ce_clk);
      if (cyc == abort_cyc) begin
        #2 ce_rst_n = 1'b0;
        #1;
        check("rst_m_vld", 64'(m_tvalid), 64'(0));
        check("rst_m_last", 64'(m_tlast), 64'(0));
        check("rst_m_data", 64'(m_tdata), 64'(0));
        check("rst_s_rdy", 64'(s_tready), 64'(1));
        check("rst_hb", 64'(hb_enables), 64'(0));
        check("rst_cic", 64'(cic_rate), 64'(1));
        check("rst_pend", 64'(cfg_pending), 64'(0));
        aborted = 1'b1;
        break;
      end
      cfg_valid = 1'b0;
      if (acc) s_tvalid = 1'b0;
      acc = 1'b0;
      if (prev_vld && !prev_rdy) begin
        check("hold_vld", 64'(m_tvalid), 64'(1));
        check("hold_data", 64'(m_tdata), 64'(prev_d));
        check("hold_last", 64'(m_tlast), 64'(prev_l));
      end
      if (cfg_at >= 0 && !cfg_done && sent == cfg_at) begin
        cfg_rate  = RATE_W'(cfg_val);
        cfg_valid = 1'b1;
        cfg_done  = 1'b1;
        cfg_cyc   = cyc;
      end
      if (cfg_done && cyc == cfg_cyc + 3) begin
        check("pend_set", 64'(cfg_pending), 64'(1));
        check_active("pend_old");
      end
      rdy      = ($urandom_range(0, 99) >= stall_pct);
      m_tready = rdy;
      if (!s_tvalid && sent < len && $urandom_range(1, 100) <= in_pct) begin
        s_tvalid = 1'b1;
        s_tdata  = pkt[sent];
        s_tlast  = (sent == len - 1);
      end
      #1;
      if (chk_rdy) check("s_rdy_full", 64'(s_tready), 64'(1));
      if (s_tvalid && s_tready) begin
        sent++;
        acc = 1'b1;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(1), 64'(0));
        end else begin
          b = exp_q.pop_front();
          check("beat_data", 64'(m_tdata), 64'(b.d));
          check("beat_last", 64'(m_tlast), 64'(b.l));
        end
      end
      prev_vld = m_tvalid;
      prev_rdy = rdy;
      prev_d   = m_tdata;
      prev_l   = m_tlast;
    end
    if (!aborted) begin
      check("pkt_done", 64'(exp_q.size() == 0 && sent == len), 64'(1));
      @(negedge ce_clk);
      s_tvalid  = 1'b0;
      cfg_valid = 1'b0;
      if (cfg_done) model_n = cfg_val;
      check("pend_after", 64'(cfg_pending), 64'(0));
      check_active("pkt_end");
    end else begin
      s_tvalid  = 1'b0;
      m_tready  = 1'b0;
      cfg_valid = 1'b0;
    end
  endtask

  initial begin
    ce_rst_n  = 1'b0;
    cfg_valid = 1'b0;
    cfg_rate  = '0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tlast   = 1'b0;
    m_tready  = 1'b0;
    #12;
    check("init_m_vld", 64'(m_tvalid), 64'(0));
    check("init_m_last", 64'(m_tlast), 64'(0));
    check("init_m_data", 64'(m_tdata), 64'(0));
    check("init_s_rdy", 64'(s_tready), 64'(1));
    check("init_hb", 64'(hb_enables), 64'(0));
    check("init_cic", 64'(cic_rate), 64'(1));
    check("init_pend", 64'(cfg_pending), 64'(0));
    check("init_err", 64'(cfg_err), 64'(0));
    @(negedge ce_clk);
    ce_rst_n = 1'b1;

    // N = 1 pass-through at full rate
    run_packet(8, 0, 100, 1'b1, -1, 0, -1, 1'b1);

    // N = 12: hb = 2, cic = 3, 48 beats
    set_cfg(12);
    check("n12_hb", 64'(hb_enables), 64'(2));
    check("n12_cic", 64'(cic_rate), 64'(3));
    run_packet(4, 0, 100, 1'b1, -1, 0, -1, 1'b0);

    // Legal maximum, then two rejected rates that must leave it in place
    set_cfg(2040);
    check("n2040_hb", 64'(hb_enables), 64'(3));
    check("n2040_cic", 64'(cic_rate), 64'(255));
    set_cfg(2041);
    set_cfg(0);
    check("keep_cic", 64'(cic_rate), 64'(255));

    // Mid-packet change is deferred to the packet boundary
    set_cfg(3);
    run_packet(5, 0, 100, 1'b1, 2, 4, -1, 1'b0);
    run_packet(5, 0, 100, 1'b1, -1, 0, -1, 1'b0);

    // Long packet under 25% output stalls
    set_cfg(13);
    run_packet(256, 25, 100, 1'b0, -1, 0, -1, 1'b0);

    // Random rates, lengths, stalls and input gaps
    repeat (4) begin
      set_cfg(int'($urandom_range(1, 20)));
      run_packet(int'($urandom_range(1, 12)), int'($urandom_range(0, 50)),
                 int'($urandom_range(50, 100)), 1'b0, -1, 0, -1, 1'b0);
    end

    // Asynchronous reset in the middle of an N = 8 packet
    set_cfg(8);
    run_packet(4, 0, 100, 1'b0, -1, 0, 15, 1'b0);
    @(negedge ce_clk);
    ce_rst_n = 1'b1;
    model_n  = 1;
    run_packet(8, 0, 100, 1'b0, -1, 0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
